// File: rtl/uart_pkg.sv
// Shared types and constants for the bit-rate UART (receive and transmit sides).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP1  = 3'd3,
    STOP2  = 3'd4
  } rx_state_t;

  localparam logic START_B = 1'b0;
  localparam logic STOP_B  = 1'b1;
  localparam int   MIN_LEN = 5;
  localparam int   MAX_LEN = 8;

  // Out-of-range frame lengths fall back to the widest frame the datapath holds.
  function automatic logic [3:0] norm_len(input logic [3:0] len, input logic [3:0] max_len);
    if ((len < 4'(MIN_LEN)) || (len > max_len)) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Expected parity bit over the low 'length' bits of a data word.
// Purely combinational so the transmit side can reuse it unchanged.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_W = MAX_LEN
) (
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        length,
  input  logic              parity_type,
  output logic              parity_bit
);

  // Even parity is the XOR of the active bits, odd parity its complement.
  function automatic logic calc_parity(input logic [DATA_W-1:0] d,
                                       input logic [3:0]        len,
                                       input logic              even);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < len) begin
        acc = acc ^ d[i];
      end
    end
    return even ? acc : ~acc;
  endfunction

  // Drive the expected parity bit from the helper.
  always_comb begin
    parity_bit = calc_parity(data, length, parity_type);
  end

endmodule

// File: rtl/uart_rx.sv
// Bit-rate UART receiver: one line bit per rx_clk edge, no oversampling.
// Deframes start / 5..DATA_W data bits (LSB first) / optional parity / 1-2 stops
// and reports data plus parity and framing errors with a one-cycle rx_done.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W = MAX_LEN
) (
  input  logic              rx_clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [3:0]        length,
  input  logic              parity_type,
  input  logic              parity_en,
  input  logic              stop2,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_err,
  output logic              parity_err,
  output logic              frame_err,
  output logic              rx_busy
);

  rx_state_t         state_r;
  rx_state_t         state_nxt_s;

  // Frame configuration, frozen at the start-bit edge.
  logic [3:0]        len_r;
  logic              ptype_r;
  logic              pen_r;
  logic              stop2_r;

  logic [3:0]        cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_flag_r;
  logic              stop_flag_r;

  logic [DATA_W-1:0] rx_data_r;
  logic              rx_done_r;
  logic              rx_err_r;
  logic              parity_err_r;
  logic              frame_err_r;
  logic              rx_busy_r;

  logic [3:0]        last_idx_s;
  logic              exp_par_s;
  logic              stop_bad_s;
  logic              complete_s;

  uart_parity_calc #(.DATA_W(DATA_W)) u_parity (
    .data        (shift_r),
    .length      (len_r),
    .parity_type (ptype_r),
    .parity_bit  (exp_par_s)
  );

  // State register.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus the per-edge strobes used by the datapath.
  always_comb begin
    state_nxt_s = state_r;
    last_idx_s  = len_r - 4'd1;
    stop_bad_s  = (rx != STOP_B);
    complete_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx == START_B) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        if (cnt_r == last_idx_s) begin
          if (pen_r) begin
            state_nxt_s = PARITY;
          end else begin
            state_nxt_s = STOP1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        state_nxt_s = STOP1;
      end
      STOP1: begin
        if (stop2_r) begin
          state_nxt_s = STOP2;
        end else begin
          state_nxt_s = IDLE;
          complete_s  = 1'b1;
        end
      end
      STOP2: begin
        state_nxt_s = IDLE;
        complete_s  = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath: config latch, bit capture, error accumulation and registered outputs.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      len_r        <= 4'(DATA_W);
      ptype_r      <= 1'b0;
      pen_r        <= 1'b0;
      stop2_r      <= 1'b0;
      cnt_r        <= 4'd0;
      shift_r      <= '0;
      par_flag_r   <= 1'b0;
      stop_flag_r  <= 1'b0;
      rx_data_r    <= '0;
      rx_done_r    <= 1'b0;
      rx_err_r     <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      rx_busy_r    <= 1'b0;
    end else begin
      rx_done_r <= 1'b0;
      rx_busy_r <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (rx == START_B) begin
            len_r       <= norm_len(length, 4'(DATA_W));
            ptype_r     <= parity_type;
            pen_r       <= parity_en;
            stop2_r     <= stop2;
            cnt_r       <= 4'd0;
            shift_r     <= '0;
            par_flag_r  <= 1'b0;
            stop_flag_r <= 1'b0;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_r == 4'(i)) begin
              shift_r[i] <= rx;
            end
          end
          cnt_r <= cnt_r + 4'd1;
        end
        PARITY: begin
          par_flag_r <= (rx != exp_par_s);
        end
        STOP1, STOP2: begin
          stop_flag_r <= stop_flag_r | stop_bad_s;
          if (complete_s) begin
            // Bits above the frame length were cleared at start, so this is zero-extended.
            rx_data_r    <= shift_r;
            parity_err_r <= pen_r & par_flag_r;
            frame_err_r  <= stop_flag_r | stop_bad_s;
            rx_err_r     <= (pen_r & par_flag_r) | stop_flag_r | stop_bad_s;
            rx_done_r    <= 1'b1;
          end
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_done    = rx_done_r;
  assign rx_err     = rx_err_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign rx_busy    = rx_busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
module tb_uart_rx;

  logic       rx_clk;
  logic       rst;
  logic       rx;
  logic [3:0] length;
  logic       parity_type;
  logic       parity_en;
  logic       stop2;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int n_cmp;
  int n_err;
  int cyc;
  int done_cnt;
  int last_done_cyc;
  int prev_done_cyc;

  uart_rx #(.DATA_W(8)) dut (
    .rx_clk      (rx_clk),
    .rst         (rst),
    .rx          (rx),
    .length      (length),
    .parity_type (parity_type),
    .parity_en   (parity_en),
    .stop2       (stop2),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_err      (rx_err),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  // Cycle counter and record of rx_done pulses.
  always @(posedge rx_clk) begin
    cyc <= cyc + 1;
    if (rx_done) begin
      done_cnt      <= done_cnt + 1;
      prev_done_cyc <= last_done_cyc;
      last_done_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rx_clk);
    #1;
  endtask

  // Drive one frame; returns just after the final stop edge. Config is scrambled
  // after the start edge to show the receiver ignores mid-frame changes.
  task automatic send_frame(input logic [7:0] data, input logic [3:0] len_cfg,
                            input logic pen, input logic ptype, input logic st2,
                            input logic par_flip, input logic s1, input logic s2);
    logic bits [0:11];
    int   n;
    int   leff;
    logic p;
    logic early;
    logic idle_seen;
    leff = ((len_cfg < 4'd5) || (len_cfg > 4'd8)) ? 8 : int'(len_cfg);
    n = 0;
    bits[n] = 1'b0; n++;
    p = 1'b0;
    for (int i = 0; i < leff; i++) begin
      bits[n] = data[i]; n++;
      p = p ^ data[i];
    end
    if (pen) begin
      if (!ptype) p = ~p;
      if (par_flip) p = ~p;
      bits[n] = p; n++;
    end
    bits[n] = s1; n++;
    if (st2) begin
      bits[n] = s2; n++;
    end
    length      = len_cfg;
    parity_en   = pen;
    parity_type = ptype;
    stop2       = st2;
    early       = 1'b0;
    idle_seen   = 1'b0;
    for (int k = 0; k < n; k++) begin
      rx = bits[k];
      step();
      if (k == 0) begin
        length      = ~len_cfg;
        parity_en   = ~pen;
        parity_type = ~ptype;
        stop2       = ~st2;
      end
      if (k < n - 1) begin
        if (rx_done) early = 1'b1;
        if (!rx_busy) idle_seen = 1'b1;
      end
    end
    rx = 1'b1;
    check_eq("early_done", 32'(early), 32'd0);
    check_eq("busy_in_frame", 32'(idle_seen), 32'd0);
    check_eq("done_at_end", 32'(rx_done), 32'd1);
    check_eq("busy_at_end", 32'(rx_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] mask;
    logic [7:0] dv;
    int         dc;
    n_cmp = 0; n_err = 0; cyc = 0; done_cnt = 0;
    last_done_cyc = 0; prev_done_cyc = 0;
    rst = 1'b1; rx = 1'b1; length = 4'd8;
    parity_type = 1'b0; parity_en = 1'b0; stop2 = 1'b0;
    step(); step();
    check_eq("rst_data", 32'(rx_data), 32'h0);
    check_eq("rst_done", 32'(rx_done), 32'd0);
    check_eq("rst_err", 32'(rx_err), 32'd0);
    check_eq("rst_perr", 32'(parity_err), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    step(); step();

    // 8N1 0xA5, done after edge S+9.
    send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("a5_data", 32'(rx_data), 32'hA5);
    check_eq("a5_err", 32'(rx_err), 32'd0);
    step();
    check_eq("a5_pulse_once", 32'(rx_done), 32'd0);
    check_eq("a5_hold", 32'(rx_data), 32'hA5);

    // Even parity, 7 bits, 0x55: good parity then flipped parity.
    send_frame(8'h55, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("ev7_data", 32'(rx_data), 32'h55);
    check_eq("ev7_perr", 32'(parity_err), 32'd0);
    check_eq("ev7_err", 32'(rx_err), 32'd0);
    send_frame(8'h55, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("ev7bad_data", 32'(rx_data), 32'h55);
    check_eq("ev7bad_perr", 32'(parity_err), 32'd1);
    check_eq("ev7bad_err", 32'(rx_err), 32'd1);
    check_eq("ev7bad_ferr", 32'(frame_err), 32'd0);

    // Odd parity, 8 bits, 0x01: expected parity bit 0.
    send_frame(8'h01, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("odd8_data", 32'(rx_data), 32'h01);
    check_eq("odd8_perr", 32'(parity_err), 32'd0);

    // 5-bit frame, two stops, second stop low: framing error, done after S+7.
    step();
    send_frame(8'h1F, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("f5_data", 32'(rx_data), 32'h1F);
    check_eq("f5_ferr", 32'(frame_err), 32'd1);
    check_eq("f5_perr", 32'(parity_err), 32'd0);
    check_eq("f5_err", 32'(rx_err), 32'd1);

    // Illegal lengths behave as 8 data bits.
    send_frame(8'hC3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("len3_data", 32'(rx_data), 32'hC3);
    check_eq("len3_err", 32'(rx_err), 32'd0);
    send_frame(8'h96, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("len15_data", 32'(rx_data), 32'h96);

    // Upper bits zeroed for a 6-bit frame.
    send_frame(8'hFF, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("len6_data", 32'(rx_data), 32'h3F);

    // Reset at edge S+3 aborts the frame without a done pulse.
    step();
    length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    dc = done_cnt;
    rx = 1'b0; step();
    rx = 1'b1; step();
    rx = 1'b0; step();
    rst = 1'b1; rx = 1'b1; step();
    rst = 1'b0;
    check_eq("abort_busy", 32'(rx_busy), 32'd0);
    check_eq("abort_data", 32'(rx_data), 32'h0);
    step(); step(); step();
    check_eq("abort_no_done", 32'(done_cnt), 32'(dc));
    send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("x3c_data", 32'(rx_data), 32'h3C);
    check_eq("x3c_err", 32'(rx_err), 32'd0);

    // Two 8N1 frames with no idle gap: pulses 10 cycles apart.
    send_frame(8'h11, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("b2b_data", 32'(rx_data), 32'h22);
    step();
    check_eq("b2b_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd10);

    // Every length / parity / stop combination, back to back.
    dc = done_cnt;
    for (int len = 5; len <= 8; len++) begin
      for (int pe = 0; pe < 2; pe++) begin
        for (int pt = 0; pt < 2; pt++) begin
          for (int s2 = 0; s2 < 2; s2++) begin
            for (int d = 0; d < 2; d++) begin
              dv   = (d == 0) ? 8'hB6 : 8'h49;
              mask = 8'((16'd1 << len) - 16'd1);
              send_frame(dv, 4'(len), 1'(pe), 1'(pt), 1'(s2), 1'b0, 1'b1, 1'b1);
              check_eq("sweep_data", 32'(rx_data), 32'(dv & mask));
              check_eq("sweep_err", 32'(rx_err), 32'd0);
            end
          end
        end
      end
    end
    step();
    check_eq("sweep_done_count", 32'(done_cnt - dc), 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive side of the team's bit-rate UART: one line bit per rx_clk cycle, no oversampling.
- Frame format matches uart_tx:
  - start bit (0), then 5..8 data bits LSB first
  - optional parity bit
  - one or two stop bits (1)
- Deframes serial rx into parallel data and reports parity/framing errors with a one-cycle done pulse.
- Sits at the far end of the serial link, or in loopback against uart_tx in the UVM env.

Parameters:
- DATA_W, 8, width of rx_data; fixed maximum data bits per frame (length legal range 5..DATA_W).

Ports:
- rx_clk  input  1  bit-rate clock; rx sampled on every posedge
- rst  input  1  reset; synchronous, active-high
- rx  input  1  serial line, idle high
- length  input  4  data bits per frame (5..8)
- parity_type  input  1  1 = even (expected bit = XOR of data), 0 = odd (XNOR)
- parity_en  input  1  1 = parity bit present after data
- stop2  input  1  1 = two stop bits expected
- rx_data  output  DATA_W  received data, zero-extended above length
- rx_done  output  1  one-cycle pulse, frame complete
- rx_err  output  1  parity_err | frame_err, valid with rx_done
- parity_err  output  1  parity mismatch on last frame
- frame_err  output  1  any expected stop bit sampled 0 on last frame
- rx_busy  output  1  high while a frame is being received (state != IDLE)

Behaviour:
- Clock and reset: one clock, rx_clk. Reset rst is synchronous, active-high.
- Reset: state=IDLE, rx_data=0, rx_done=0, rx_err=0, parity_err=0, frame_err=0, rx_busy=0, bit counter=0, shift reg=0. A reset mid-frame discards the partial frame, and no rx_done is produced for it.
- Outputs: all registered; no combinational path from rx to any output.
- Config latch: length, parity_type, parity_en and stop2 are captured on the start-detect edge and held for the whole frame. Mid-frame config changes are ignored.
- Illegal length (0..4, 9..15): treated as 8.
- States (enum in package):
  - IDLE: posedge with rx==0 → DATA (that edge is the start-bit sample, edge S). rx==1 → stay.
  - DATA: samples one bit per edge into bit index cnt, at edges S+1..S+L. After bit L-1: parity_en → PARITY, else → STOP1.
  - PARITY: samples the parity bit at edge S+L+1; compares with the XOR/XNOR of the L received bits. → STOP1.
  - STOP1: samples stop 1; rx==0 sets the frame-error flag. stop2 → STOP2, else → IDLE.
  - STOP2: samples stop 2; rx==0 sets the frame-error flag. → IDLE.
- Completion, on the edge that samples the final stop bit:
  - rx_data <= received bits, zero-extended above length.
  - parity_err <= mismatch (0 if parity disabled); frame_err <= accumulated stop flag; rx_err <= OR of the two.
  - rx_done <= 1 for exactly one cycle.
  - rx_data and the error flags hold until the next completion or reset.
- Latency: rx_done is high in the cycle after edge S+L+P+N (P = parity_en, N = 1 or 2 stop bits). Example: L=8, no parity, one stop → edge S+9.
- Back-to-back frames: the FSM is in IDLE on the cycle after the final stop sample, so a start bit on the very next edge is accepted. No idle gap is required.
- A framing error still completes the frame and returns to IDLE; the receiver does not resync or wait for the line to go high. A low line after a bad stop is taken as the next start bit.
- rx held low after reset release is treated as a start bit. This is a documented limitation; there is no glitch filter.

Decomposition:
- uart_pkg:
  - rx_state_t enum: IDLE, DATA, PARITY, STOP1, STOP2
  - START_B=1'b0, STOP_B=1'b1, MIN_LEN=5, MAX_LEN=8
- One sub-module: uart_parity_calc (data, length, parity_type → expected parity bit). It is combinational and reusable by uart_tx.

Test Plan:
- Basic 8N1, 0xA5:
  - Stimulus: length=8, parity_en=0, stop2=0; rx = 0,1,0,1,0,0,1,0,1,1 from edge S.
  - Response: rx_done=1 in the cycle after edge S+9; rx_data=8'hA5; rx_err=0; rx_busy high from S+1 through S+9.
- Even parity, 7 data bits, 0x55:
  - Stimulus: length=7, parity_type=1, parity_en=1; parity bit 0.
  - Response: rx_data=8'h55, parity_err=0.
  - Repeat the frame with parity bit 1 → parity_err=1, rx_err=1, frame_err=0.
- 5-bit frame, two stops:
  - Stimulus: length=5, stop2=1; data bits 1,1,1,1,1; stop bits 1 then 0.
  - Response: rx_data=8'h1F; frame_err=1; rx_done after edge S+7.
- Reset and back-to-back:
  - Stimulus: assert rst for 1 cycle at edge S+3 of a frame, then send a clean 0x3C 8N1 frame.
  - Response: no rx_done for the aborted frame; next frame gives rx_data=8'h3C, rx_err=0.
  - Then send two frames with no idle gap → two rx_done pulses exactly 10 cycles apart.
- Loopback against uart_tx:
  - Stimulus: 256 data values × every length/parity/stop combination, sharing rx_clk = tx_clk.
  - Response: rx_data equals tx_data masked to length, rx_err=0, one rx_done per tx_done.
